// File: rtl/vn_pkg.sv
// vn_pkg: shared helpers for the variable-node pipeline (sizing, LLR format conversion, clipping)
package vn_pkg;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int lvl_cnt(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction
    function automatic int pos_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
    function automatic int neg_max(input int w);
        return -pos_max(w);
    endfunction
    // -0 has zero magnitude, so it falls out as 0 without a special case
    function automatic int sm2tc(input logic [31:0] sm, input int w);
        logic [31:0] s = sm >> (w - 1);
        int mag = int'(sm & 32'(pos_max(w)));
        return s[0] ? -mag : mag;
    endfunction
    function automatic logic [31:0] tc2sm(input int v, input int w);
        return v < 0 ? ((32'd1 << (w - 1)) | 32'(-v)) : 32'(v);
    endfunction
    function automatic int saturate(input int v, input int w);
        return v > pos_max(w) ? pos_max(w) : v < neg_max(w) ? neg_max(w) : v;
    endfunction
endpackage

// File: rtl/vn_adder_tree.sv
// vn_adder_tree: pipelined binary adder tree, one level per register, odd operands carried through
module vn_adder_tree
    import vn_pkg::*;
#(
    parameter int N = 9,
    parameter int W = 6,
    localparam int STG = clog2(N),
    localparam int OW = W + STG
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [N*W-1:0] i_ops,
    output logic          o_valid,
    output logic [OW-1:0] o_sum
);
    genvar l, j;
    logic [STG-1:0] vld_q;
    for (l = 0; l <= STG; l++) begin : g_lvl
        localparam int C = lvl_cnt(N, l);
        localparam int P = lvl_cnt(N, (l > 0) ? l - 1 : 0);
        for (j = 0; j < C; j++) begin : g_nd
            logic signed [OW-1:0] q;
            if (l == 0) begin : g_in
                assign q = {{STG{i_ops[j*W+W-1]}}, i_ops[j*W +: W]};
            end else if (2 * j + 1 < P) begin : g_add
                always_ff @(posedge i_clk)
                    q <= g_lvl[l-1].g_nd[2*j].q + g_lvl[l-1].g_nd[2*j+1].q;
            end else begin : g_pass
                always_ff @(posedge i_clk)
                    q <= g_lvl[l-1].g_nd[2*j].q;
            end
        end
    end
    always_ff @(posedge i_clk)
        if (!i_rst_n) vld_q <= '0;
        else vld_q <= {vld_q[STG-2:0], i_valid};
    assign o_valid = vld_q[STG-1];
    assign o_sum = g_lvl[STG].g_nd[0].q;
endmodule

// File: rtl/vn_pipe.sv
// vn_pipe: fully pipelined LDPC variable node producing APP sum, hard decision and clipped v2c messages
module vn_pipe
    import vn_pkg::*;
#(
    parameter int MSG_WIDTH = 6,
    parameter int COL_NUM = 8,
    localparam int TREE_STG = clog2(COL_NUM + 1),
    localparam int SUM_W = MSG_WIDTH + TREE_STG
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic                         i_init,
    input  logic [COL_NUM-1:0]           i_col_mask,
    input  logic [MSG_WIDTH-1:0]         i_llr,
    input  logic [MSG_WIDTH*COL_NUM-1:0] i_c2v_bus,
    output logic                         o_valid,
    output logic [SUM_W-1:0]             o_app,
    output logic                         o_app_sign,
    output logic [MSG_WIDTH*COL_NUM-1:0] o_v2c_bus,
    output logic                         o_sat
);
    logic [COL_NUM-1:0][MSG_WIDTH-1:0] c2v_d, c2v_q, v2c_d, v2c_q;
    logic [TREE_STG-1:0][COL_NUM-1:0][MSG_WIDTH-1:0] c2v_dl_q;
    logic [TREE_STG-1:0][COL_NUM-1:0] mask_dl_q;
    logic [MSG_WIDTH-1:0] llr_q;
    logic [COL_NUM-1:0] mask_q;
    logic vld_q, tree_vld, out_vld_q, sat_d, sat_q;
    logic signed [SUM_W-1:0] sum, app_q;
    logic signed [SUM_W:0] diff [COL_NUM];

    always_comb
        for (int i = 0; i < COL_NUM; i++)
            c2v_d[i] = (i_init || !i_col_mask[i]) ? '0
                     : MSG_WIDTH'(sm2tc(32'(i_c2v_bus[i*MSG_WIDTH +: MSG_WIDTH]), MSG_WIDTH));

    // data path is free-running; only the valid bits need a reset
    always_ff @(posedge i_clk) begin
        llr_q <= i_llr;
        c2v_q <= c2v_d;
        mask_q <= i_col_mask;
        c2v_dl_q <= {c2v_dl_q[TREE_STG-2:0], c2v_q};
        mask_dl_q <= {mask_dl_q[TREE_STG-2:0], mask_q};
    end

    always_ff @(posedge i_clk)
        if (!i_rst_n) vld_q <= 1'b0;
        else vld_q <= i_valid;

    vn_adder_tree #(.N(COL_NUM + 1), .W(MSG_WIDTH)) u_tree (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (vld_q),
        .i_ops   ({c2v_q, llr_q}),
        .o_valid (tree_vld),
        .o_sum   (sum)
    );

    always_comb begin
        v2c_d = '0;
        sat_d = 1'b0;
        for (int i = 0; i < COL_NUM; i++) begin
            diff[i] = (SUM_W+1)'(sum) - (SUM_W+1)'(signed'(c2v_dl_q[TREE_STG-1][i]));
            if (mask_dl_q[TREE_STG-1][i]) begin
                v2c_d[i] = MSG_WIDTH'(tc2sm(saturate(int'(diff[i]), MSG_WIDTH), MSG_WIDTH));
                sat_d = sat_d | (int'(diff[i]) != saturate(int'(diff[i]), MSG_WIDTH));
            end
        end
    end

    always_ff @(posedge i_clk)
        if (!i_rst_n) begin
            out_vld_q <= 1'b0;
            app_q <= '0;
            v2c_q <= '0;
            sat_q <= 1'b0;
        end else begin
            out_vld_q <= tree_vld;
            if (tree_vld) begin
                app_q <= sum;
                v2c_q <= v2c_d;
                sat_q <= sat_d;
            end
        end

    assign o_valid = out_vld_q;
    assign o_app = app_q;
    assign o_app_sign = app_q[SUM_W-1];
    assign o_v2c_bus = v2c_q;
    assign o_sat = sat_q;
endmodule

// File: tb/tb_vn_pipe.sv
// tb_vn_pipe: scoreboard bench for vn_pipe with directed vectors and a cycle-exact random stream
module tb_vn_pipe;
    localparam int MW = 6;
    localparam int CN = 8;
    localparam int SW = 10;
    localparam int L = 6;

    typedef struct {
        int          due;
        logic [SW-1:0] app;
        logic        sign;
        logic [MW*CN-1:0] v2c;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_init = 1'b0;
    logic [CN-1:0] i_col_mask = '0;
    logic [MW-1:0] i_llr = '0;
    logic [MW*CN-1:0] i_c2v_bus = '0;
    logic o_valid, o_app_sign, o_sat;
    logic [SW-1:0] o_app;
    logic [MW*CN-1:0] o_v2c_bus;

    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int checks = 0;
    int errs = 0;
    logic rst_s = 1'b0;
    logic last_ok = 1'b0;
    logic [SW+MW*CN+1:0] last = '0;

    vn_pipe dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .i_init     (i_init),
        .i_col_mask (i_col_mask),
        .i_llr      (i_llr),
        .i_c2v_bus  (i_c2v_bus),
        .o_valid    (o_valid),
        .o_app      (o_app),
        .o_app_sign (o_app_sign),
        .o_v2c_bus  (o_v2c_bus),
        .o_sat      (o_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_s <= !rst_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [MW*CN-1:0] rep(input logic [MW-1:0] m);
        return {CN{m}};
    endfunction

    function automatic exp_t model(input logic [MW-1:0] llr, input logic [MW*CN-1:0] c2v,
                                   input logic [CN-1:0] mask, input logic init);
        int c [CN];
        int s, d, cl;
        exp_t r;
        s = int'(signed'(llr));
        r.v2c = '0;
        r.sat = 1'b0;
        for (int i = 0; i < CN; i++) begin
            if (init || !mask[i]) c[i] = 0;
            else c[i] = c2v[MW*i+MW-1] ? -int'(c2v[MW*i +: MW-1]) : int'(c2v[MW*i +: MW-1]);
            s += c[i];
        end
        for (int i = 0; i < CN; i++)
            if (mask[i]) begin
                d = s - c[i];
                cl = d > 31 ? 31 : d < -31 ? -31 : d;
                if (cl != d) r.sat = 1'b1;
                r.v2c[MW*i +: MW] = cl < 0 ? {1'b1, 5'(-cl)} : {1'b0, 5'(cl)};
            end
        r.app = SW'(s);
        r.sign = s < 0;
        r.due = 0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [MW-1:0] llr, input logic [MW*CN-1:0] c2v,
                         input logic [CN-1:0] m, input logic init);
        i_valid = v;
        i_llr = llr;
        i_c2v_bus = c2v;
        i_col_mask = m;
        i_init = init;
    endtask

    task automatic dir(input logic [MW-1:0] llr, input logic [MW*CN-1:0] c2v, input logic [CN-1:0] m,
                       input logic init, input int app, input logic [MW*CN-1:0] v2c, input logic sat);
        exp_t x;
        @(posedge clk);
        #1;
        drive(1'b1, llr, c2v, m, init);
        x.due = cyc + L;
        x.app = SW'(app);
        x.sign = app < 0;
        x.v2c = v2c;
        x.sat = sat;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_s) begin
            chk("reset", 64'({o_valid, o_app_sign, o_app, o_v2c_bus, o_sat}), 64'd0);
            last = '0;
            last_ok = 1'b1;
        end else if (o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_valid at cycle %0d: got o_valid=1 expected 0", cyc);
            end else begin
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                chk("app", 64'(o_app), 64'(e.app));
                chk("app_sign", 64'(o_app_sign), 64'(e.sign));
                chk("v2c", 64'(o_v2c_bus), 64'(e.v2c));
                chk("sat", 64'(o_sat), 64'(e.sat));
            end
            last = {o_app_sign, o_app, o_v2c_bus, o_sat};
            last_ok = 1'b1;
        end else if (last_ok) begin
            chk("hold", 64'({o_app_sign, o_app, o_v2c_bus, o_sat}), 64'(last));
        end
    end

    initial begin
        exp_t x;
        logic [MW-1:0] llr;
        logic [MW*CN-1:0] c2v;
        logic [CN-1:0] m;
        logic init;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        dir(6'd5, rep(6'b000001), 8'hFF, 1'b0, 13, rep(6'b001100), 1'b0);
        dir(6'd31, rep(6'b011111), 8'hFF, 1'b0, 279, rep(6'b011111), 1'b1);
        dir(6'b100001, rep(6'b111111), 8'hFF, 1'b0, -279, rep(6'b111111), 1'b1);
        dir(6'b111100, {{6{6'b001010}}, 6'b100010, 6'b000011}, 8'b00000011, 1'b0,
            -3, {36'd0, 6'b100001, 6'b100110}, 1'b0);
        dir(6'b111001, 48'({$urandom(), $urandom()}), 8'hFF, 1'b1, -7, rep(6'b100111), 1'b0);
        dir(6'd0, rep(6'b100000), 8'hFF, 1'b0, 0, rep(6'b000000), 1'b0);
        dir(6'b100000, 48'({$urandom(), $urandom()}), 8'h00, 1'b0, -32, 48'd0, 1'b0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 50) begin
                rst_n = 1'b0;
                drive(1'b1, 6'($urandom()), 48'({$urandom(), $urandom()}), 8'hFF, 1'b0);
                @(posedge clk);
                #1;
                q.delete();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                i_valid = 1'b0;
                continue;
            end
            if ($urandom_range(3) == 0) begin
                i_valid = 1'b0;
                continue;
            end
            llr = 6'($urandom());
            c2v = 48'({$urandom(), $urandom()});
            m = ($urandom_range(2) == 0) ? 8'($urandom()) : 8'hFF;
            init = $urandom_range(7) == 0;
            drive(1'b1, llr, c2v, m, init);
            x = model(llr, c2v, m, init);
            x.due = cyc + L;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d outstanding samples expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
